// File: rtl/mem_sync_xfer_if.sv
// mem_sync_xfer_if
// Bundles the per-bank sync request side and the beat-level memory bus of
// mem_sync_xfer into one parameterised interface.
//
// Signals (NBANKS = 2**(BGWIDTH+BAWIDTH), flat bank index = {bg,ba}):
//   req        [NBANKS]            level request per bank, held until sync
//   op         [NBANKS]            0 = fill (DRAM->cache), 1 = writeback
//   RowId      [NBANKS*ADDRWIDTH]  DRAM row per bank, bank i at [i*ADDRWIDTH +: ADDRWIDTH]
//   cRowId     [NBANKS*CHWIDTH]    cache row per bank, bank i at [i*CHWIDTH +: CHWIDTH]
//   mem_valid                      beat request valid
//   mem_ready                      beat accepted when mem_valid && mem_ready
//   mem_wr                         direction of the transfer in progress
//   mem_addr                       {bank, row, beat}
//   cache_addr                     {cRow, beat}
//   sync       [NBANKS]            one-cycle completion pulse to served bank
//   busy                           engine not idle
//
// Modports:
//   master - the transfer engine (drives the memory bus and sync/busy)
//   slave  - requesters plus memory model (drive req/op/rows and mem_ready)
interface mem_sync_xfer_if #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int BEATWIDTH = 3
) ();
    localparam int BKWIDTH = BGWIDTH + BAWIDTH;
    localparam int NBANKS  = 2 ** BKWIDTH;
    localparam int MAWIDTH = BKWIDTH + ADDRWIDTH + BEATWIDTH;
    localparam int CAWIDTH = CHWIDTH + BEATWIDTH;

    logic [NBANKS-1:0]           req;
    logic [NBANKS-1:0]           op;
    logic [NBANKS*ADDRWIDTH-1:0] RowId;
    logic [NBANKS*CHWIDTH-1:0]   cRowId;
    logic                        mem_valid;
    logic                        mem_ready;
    logic                        mem_wr;
    logic [MAWIDTH-1:0]          mem_addr;
    logic [CAWIDTH-1:0]          cache_addr;
    logic [NBANKS-1:0]           sync;
    logic                        busy;

    modport master (
        input  req, op, RowId, cRowId, mem_ready,
        output mem_valid, mem_wr, mem_addr, cache_addr, sync, busy
    );

    modport slave (
        output req, op, RowId, cRowId, mem_ready,
        input  mem_valid, mem_wr, mem_addr, cache_addr, sync, busy
    );
endinterface

// File: rtl/mem_sync_xfer.sv
// mem_sync_xfer
// Row synchronisation engine between a DRAM and a row cache. Banks raise a
// level request; one bank at a time is granted round-robin, its direction and
// row addresses are latched, and the whole row is moved as BEATS = 2**BEATWIDTH
// valid/ready beats. Completion is signalled by a one-cycle sync pulse to the
// served bank.
//
// Ports:
//   clk      - single clock, rising edge
//   reset_n  - asynchronous, active-low reset
//   bus      - mem_sync_xfer_if.master: req/op/RowId/cRowId/mem_ready in,
//              mem_valid/mem_wr/mem_addr/cache_addr/sync/busy out
module mem_sync_xfer #(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 6,
    parameter int ADDRWIDTH = 17,
    parameter int BEATWIDTH = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_sync_xfer_if.master  bus
);
    localparam int BKWIDTH = BGWIDTH + BAWIDTH;
    localparam int NBANKS  = 2 ** BKWIDTH;
    localparam int MAWIDTH = BKWIDTH + ADDRWIDTH + BEATWIDTH;
    localparam int CAWIDTH = CHWIDTH + BEATWIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [BKWIDTH-1:0]     bank_q, bank_d;
    logic [BKWIDTH-1:0]     last_grant_q, last_grant_d;
    logic                   blank_q, blank_d;
    logic                   op_q, op_d;
    logic [ADDRWIDTH-1:0]   row_q, row_d;
    logic [CHWIDTH-1:0]     crow_q, crow_d;
    logic [BEATWIDTH-1:0]   beat_q, beat_d;

    logic [NBANKS-1:0]      eligible;
    logic [BKWIDTH-1:0]     cand;
    logic                   grant_vld;
    logic [BKWIDTH-1:0]     grant_idx;

    logic                   mem_valid;
    logic                   mem_wr;
    logic [MAWIDTH-1:0]     mem_addr;
    logic [CAWIDTH-1:0]     cache_addr;
    logic [NBANKS-1:0]      sync;

    // The bank served last is masked for exactly one IDLE cycle so a requester
    // that drops req one cycle after its sync pulse is not served twice.
    always_comb begin
        eligible = bus.req;
        if (blank_q) begin
            eligible[last_grant_q] = 1'b0;
        end
    end

    // Round-robin search from last_grant+1 upward; the BKWIDTH-bit add wraps
    // naturally, and the final candidate is last_grant itself.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NBANKS; i++) begin
            cand = last_grant_q + BKWIDTH'(i);
            if (!grant_vld && eligible[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            bank_q       <= '0;
            last_grant_q <= '1;
            blank_q      <= 1'b0;
            op_q         <= 1'b0;
            row_q        <= '0;
            crow_q       <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            last_grant_q <= last_grant_d;
            blank_q      <= blank_d;
            op_q         <= op_d;
            row_q        <= row_d;
            crow_q       <= crow_d;
            beat_q       <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        last_grant_d = last_grant_q;
        blank_d      = blank_q;
        op_d         = op_q;
        row_d        = row_q;
        crow_d       = crow_q;
        beat_d       = beat_q;

        mem_valid    = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        cache_addr   = '0;
        sync         = '0;

        unique case (state_q)
            IDLE: begin
                blank_d = 1'b0;
                if (grant_vld) begin
                    bank_d  = grant_idx;
                    op_d    = bus.op[grant_idx];
                    row_d   = bus.RowId[int'(grant_idx) * ADDRWIDTH +: ADDRWIDTH];
                    crow_d  = bus.cRowId[int'(grant_idx) * CHWIDTH +: CHWIDTH];
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                mem_valid  = 1'b1;
                mem_wr     = op_q;
                mem_addr   = {bank_q, row_q, beat_q};
                cache_addr = {crow_q, beat_q};
                if (bus.mem_ready) begin
                    if (beat_q == '1) begin
                        beat_d  = '0;
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            DONE: begin
                sync[bank_q] = 1'b1;
                last_grant_d = bank_q;
                blank_d      = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_valid  = mem_valid;
    assign bus.mem_wr     = mem_wr;
    assign bus.mem_addr   = mem_addr;
    assign bus.cache_addr = cache_addr;
    assign bus.sync       = sync;
    assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_sync_xfer.sv
// tb_mem_sync_xfer
// Directed bench for mem_sync_xfer: reset values, single fill, writeback with
// backpressure, round-robin order, held request blanking, reset mid-transfer
// and input changes during a transfer. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_mem_sync_xfer;
    localparam int BGW   = 2;
    localparam int BAW   = 2;
    localparam int CHW   = 6;
    localparam int AW    = 17;
    localparam int BW    = 3;
    localparam int BEATS = 8;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mem_sync_xfer_if #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .CHWIDTH(CHW), .ADDRWIDTH(AW), .BEATWIDTH(BW)
    ) bif ();

    mem_sync_xfer #(
        .BGWIDTH(BGW), .BAWIDTH(BAW), .CHWIDTH(CHW), .ADDRWIDTH(AW), .BEATWIDTH(BW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bank(input int b, input logic o,
                            input logic [AW-1:0] row, input logic [CHW-1:0] crow);
        bif.op[b]                = o;
        bif.RowId[b*AW +: AW]    = row;
        bif.cRowId[b*CHW +: CHW] = crow;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"}, 64'(bif.mem_valid), 64'd0);
        check({tag, ".sync"},  64'(bif.sync),      64'd0);
        check({tag, ".busy"},  64'(bif.busy),      64'd0);
        check({tag, ".wr"},    64'(bif.mem_wr),    64'd0);
        check({tag, ".maddr"}, 64'(bif.mem_addr),  64'd0);
        check({tag, ".caddr"}, 64'(bif.cache_addr), 64'd0);
    endtask

    // Called on the falling edge where beat 0 must be visible; returns on the
    // falling edge of the DONE cycle after checking the sync pulse. At beat
    // chg_beat the bank's op/RowId/cRowId are inverted to show they are ignored.
    task automatic xfer(input string tag, input int b, input logic wr,
                        input logic [AW-1:0] row, input logic [CHW-1:0] crow,
                        input int chg_beat);
        bif.mem_ready = 1'b1;
        for (int k = 0; k < BEATS; k++) begin
            check({tag, ".valid"}, 64'(bif.mem_valid), 64'd1);
            check({tag, ".maddr"}, 64'(bif.mem_addr), 64'({4'(b), row, 3'(k)}));
            check({tag, ".caddr"}, 64'(bif.cache_addr), 64'({crow, 3'(k)}));
            check({tag, ".wr"},    64'(bif.mem_wr), 64'(wr));
            check({tag, ".sync"},  64'(bif.sync), 64'd0);
            check({tag, ".busy"},  64'(bif.busy), 64'd1);
            if (k == chg_beat) begin
                bif.RowId[b*AW +: AW]    = ~row;
                bif.cRowId[b*CHW +: CHW] = ~crow;
                bif.op[b]                = ~wr;
            end
            @(negedge clk);
        end
        check({tag, ".done_sync"},  64'(bif.sync), 64'd1 << b);
        check({tag, ".done_valid"}, 64'(bif.mem_valid), 64'd0);
        check({tag, ".done_busy"},  64'(bif.busy), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int beat;
        int cyc;

        reset_n       = 1'b0;
        bif.req       = '0;
        bif.op        = '0;
        bif.RowId     = '0;
        bif.cRowId    = '0;
        bif.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        reset_n = 1'b1;

        // Single fill on bank 0.
        set_bank(0, 1'b0, 17'h1ABCD, 6'd5);
        bif.req[0] = 1'b1;
        @(negedge clk);
        xfer("fill0", 0, 1'b0, 17'h1ABCD, 6'd5, -1);
        bif.req[0] = 1'b0;
        @(negedge clk);
        check("fill0.after_sync", 64'(bif.sync), 64'd0);
        check("fill0.after_busy", 64'(bif.busy), 64'd0);

        // Writeback on bank 6 with mem_ready pattern 1,0,0,1 repeating.
        set_bank(6, 1'b1, 17'h0F0F0, 6'd33);
        bif.req[6]    = 1'b1;
        bif.mem_ready = 1'b0;
        @(negedge clk);
        beat = 0;
        cyc  = 0;
        while (beat < BEATS && cyc < 64) begin
            bif.mem_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            check("bp.valid", 64'(bif.mem_valid), 64'd1);
            check("bp.maddr", 64'(bif.mem_addr), 64'({4'd6, 17'h0F0F0, 3'(beat)}));
            check("bp.caddr", 64'(bif.cache_addr), 64'({6'd33, 3'(beat)}));
            check("bp.wr",    64'(bif.mem_wr), 64'd1);
            check("bp.sync",  64'(bif.sync), 64'd0);
            if (bif.mem_ready) beat++;
            cyc++;
            @(negedge clk);
        end
        check("bp.cycles", 64'(cyc), 64'd16);
        check("bp.done_sync",  64'(bif.sync), 64'h0040);
        check("bp.done_valid", 64'(bif.mem_valid), 64'd0);
        bif.req[6]    = 1'b0;
        bif.mem_ready = 1'b1;
        @(negedge clk);
        check("bp.after_sync", 64'(bif.sync), 64'd0);

        // Round-robin from reset with req = 16'h8003.
        reset_n = 1'b0;
        @(negedge clk);
        check_zero("rst2");
        reset_n = 1'b1;
        set_bank(0,  1'b0, 17'h00100, 6'd10);
        set_bank(1,  1'b0, 17'h00101, 6'd11);
        set_bank(15, 1'b0, 17'h0010F, 6'd15);
        bif.req = 16'h8003;
        @(negedge clk);
        xfer("rr0", 0, 1'b0, 17'h00100, 6'd10, -1);
        bif.req[0] = 1'b0;
        @(negedge clk);
        check("rr.gap0_busy", 64'(bif.busy), 64'd0);
        // bank 0 asks again while bank 1 is still waiting
        bif.req[0] = 1'b1;
        @(negedge clk);
        xfer("rr1", 1, 1'b0, 17'h00101, 6'd11, -1);
        bif.req[1] = 1'b0;
        @(negedge clk);
        check("rr.gap1_busy", 64'(bif.busy), 64'd0);
        @(negedge clk);
        xfer("rr15", 15, 1'b0, 17'h0010F, 6'd15, -1);
        bif.req[15] = 1'b0;
        @(negedge clk);
        check("rr.gap15_busy", 64'(bif.busy), 64'd0);
        @(negedge clk);
        xfer("rr0b", 0, 1'b0, 17'h00100, 6'd10, -1);
        bif.req[0] = 1'b0;
        @(negedge clk);

        // Requester holds req[3] one cycle past its sync pulse.
        set_bank(3, 1'b0, 17'h1F00F, 6'd63);
        bif.req[3] = 1'b1;
        @(negedge clk);
        xfer("held3", 3, 1'b0, 17'h1F00F, 6'd63, -1);
        @(negedge clk);
        check("held3.blank_busy", 64'(bif.busy), 64'd0);
        bif.req[3] = 1'b0;
        @(negedge clk);
        check("held3.no_rerun_busy",  64'(bif.busy), 64'd0);
        check("held3.no_rerun_valid", 64'(bif.mem_valid), 64'd0);

        // Reset while bank 2 is at beat 4, then restart from beat 0.
        set_bank(2, 1'b0, 17'h1234A, 6'd7);
        bif.req[2] = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            check("rst_mid.maddr", 64'(bif.mem_addr), 64'({4'd2, 17'h1234A, 3'(k)}));
            @(negedge clk);
        end
        check("rst_mid.beat4", 64'(bif.mem_addr), 64'({4'd2, 17'h1234A, 3'd4}));
        reset_n = 1'b0;
        #1;
        check_zero("rst_mid");
        @(negedge clk);
        check("rst_mid.hold_sync", 64'(bif.sync), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        xfer("restart2", 2, 1'b0, 17'h1234A, 6'd7, -1);
        bif.req[2] = 1'b0;
        @(negedge clk);

        // Bank 5 inputs change at beat 3; the latched transfer is unaffected.
        set_bank(5, 1'b0, 17'h0AAAA, 6'd9);
        bif.req[5] = 1'b1;
        @(negedge clk);
        xfer("chg5", 5, 1'b0, 17'h0AAAA, 6'd9, 3);
        bif.req[5] = 1'b0;
        @(negedge clk);
        check("chg5.after_busy", 64'(bif.busy), 64'd0);
        check("chg5.after_sync", 64'(bif.sync), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
